// File: rtl/parking_sensor_decoder.sv
// rtl/parking_sensor_decoder.sv - gate photo-sensor sync/debounce and car direction decoder
// Emits single-cycle enter/exit pulses for the occupancy counter from two beam sensors.
module parking_sensor_decoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic enter,
  output logic exit,
  output logic err,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERR} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             enter_nxt;
  logic             exit_nxt;
  logic             err_nxt;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [CNT_W-1:0] cnt [2];
  logic             da;
  logic             db;
  logic [1:0]       pair;

  assign da   = deb[0];
  assign db   = deb[1];
  assign pair = {da, db};

  // Bit 0 carries sensor a, bit 1 carries sensor b through sync and debounce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {sensor_b, sensor_a};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    enter_nxt = 1'b0;
    exit_nxt  = 1'b0;
    case (state)
      IDLE: case (pair)
        2'b10:   state_nxt = IN1;
        2'b01:   state_nxt = OUT1;
        2'b11:   state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
      IN1: case (pair)
        2'b11:   state_nxt = IN2;
        2'b00:   state_nxt = IDLE;
        2'b01:   state_nxt = ERR;
        default: state_nxt = IN1;
      endcase
      IN2: case (pair)
        2'b01:   state_nxt = IN3;
        2'b10:   state_nxt = IN1;
        2'b00:   state_nxt = ERR;
        default: state_nxt = IN2;
      endcase
      IN3: case (pair)
        2'b00: begin
          state_nxt = IDLE;
          enter_nxt = 1'b1;
        end
        2'b11:   state_nxt = IN2;
        2'b10:   state_nxt = ERR;
        default: state_nxt = IN3;
      endcase
      OUT1: case (pair)
        2'b11:   state_nxt = OUT2;
        2'b00:   state_nxt = IDLE;
        2'b10:   state_nxt = ERR;
        default: state_nxt = OUT1;
      endcase
      OUT2: case (pair)
        2'b10:   state_nxt = OUT3;
        2'b01:   state_nxt = OUT1;
        2'b00:   state_nxt = ERR;
        default: state_nxt = OUT2;
      endcase
      OUT3: case (pair)
        2'b00: begin
          state_nxt = IDLE;
          exit_nxt  = 1'b1;
        end
        2'b11:   state_nxt = OUT2;
        2'b01:   state_nxt = ERR;
        default: state_nxt = OUT3;
      endcase
      ERR: state_nxt = (pair == 2'b00) ? IDLE : ERR;
    endcase
    err_nxt = (state_nxt == ERR) && (state != ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      enter <= 1'b0;
      exit  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      enter <= enter_nxt;
      exit  <= exit_nxt;
      err   <= err_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_parking_sensor_decoder.sv
// tb/tb_parking_sensor_decoder.sv - self-checking bench for parking_sensor_decoder
// Path-based reference model compared every cycle, plus literal timing expectations.
module tb_parking_sensor_decoder;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sensor_a = 1'b0;
  logic sensor_b = 1'b0;
  logic enter;
  logic exit;
  logic err;
  logic busy;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  parking_sensor_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .enter(enter), .exit(exit), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sync delay, D-sample history debounce, passage as a walk along a path.
  bit m_s1[2] = '{0, 0};
  bit m_sync[2] = '{0, 0};
  bit m_deb[2] = '{0, 0};
  bit m_hist[2][D];
  int m_mode = 0;
  int m_pos = 0;
  bit m_en = 0, m_ex = 0, m_er = 0, m_busy = 0;

  function automatic logic [1:0] path(input int dir, input int k);
    logic [1:0] p;
    case (k)
      1:       p = (dir == 0) ? 2'b10 : 2'b01;
      2:       p = 2'b11;
      3:       p = (dir == 0) ? 2'b01 : 2'b10;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_sync[i] = 0; m_deb[i] = 0;
        for (int k = 0; k < D; k++) m_hist[i][k] = 0;
      end
      m_mode = 0; m_pos = 0;
      m_en = 0; m_ex = 0; m_er = 0; m_busy = 0;
    end else begin
      logic [1:0] p;
      int dir;
      bit all_diff;
      p = {m_deb[0], m_deb[1]};
      m_en = 0; m_ex = 0; m_er = 0;
      case (m_mode)
        0: begin
          if (p == path(0, 1)) begin m_mode = 1; m_pos = 1; end
          else if (p == path(1, 1)) begin m_mode = 2; m_pos = 1; end
          else if (p != 2'b00) begin m_mode = 3; m_er = 1; end
        end
        1, 2: begin
          dir = m_mode - 1;
          if (p == path(dir, m_pos)) begin
          end else if (m_pos < 3 && p == path(dir, m_pos + 1)) begin
            m_pos++;
          end else if (p == path(dir, m_pos - 1)) begin
            m_pos--;
            if (m_pos == 0) m_mode = 0;
          end else if (m_pos == 3 && p == 2'b00) begin
            if (dir == 0) m_en = 1; else m_ex = 1;
            m_mode = 0; m_pos = 0;
          end else begin
            m_mode = 3; m_er = 1;
          end
        end
        default: if (p == 2'b00) m_mode = 0;
      endcase
      m_busy = (m_mode != 0);
      for (int i = 0; i < 2; i++) begin
        for (int k = D - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = m_sync[i];
        all_diff = 1;
        for (int k = 0; k < D; k++) if (m_hist[i][k] == m_deb[i]) all_diff = 0;
        if (all_diff) m_deb[i] = m_sync[i];
      end
      m_sync[0] = m_s1[0]; m_sync[1] = m_s1[1];
      m_s1[0] = sensor_a;  m_s1[1] = sensor_b;
    end
  end

  int cnt_en = 0, cnt_ex = 0, cnt_er = 0, cnt_busy = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_enter", enter, m_en);
      check("model_exit", exit, m_ex);
      check("model_err", err, m_er);
      check("model_busy", busy, m_busy);
      if (enter && exit) check("enter_exit_exclusive", 1, 0);
      cnt_en += int'(enter);
      cnt_ex += int'(exit);
      cnt_er += int'(err);
      cnt_busy += int'(busy);
    end
  end

  int e_en, e_ex, e_er, e_bz;

  // Drive raw (a,b) for n cycles; record the first edge index of each pulse and of a busy change.
  task automatic hold(input logic a, input logic b, input int n);
    logic busy0;
    busy0 = busy;
    e_en = 0; e_ex = 0; e_er = 0; e_bz = 0;
    sensor_a = a;
    sensor_b = b;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (enter && e_en == 0) e_en = i;
      if (exit && e_ex == 0) e_ex = i;
      if (err && e_er == 0) e_er = i;
      if (busy != busy0 && e_bz == 0) e_bz = i;
    end
  endtask

  int b_en, b_ex, b_er, b_bz;

  task automatic snap();
    b_en = cnt_en; b_ex = cnt_ex; b_er = cnt_er; b_bz = cnt_busy;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check("reset_outputs", {enter, exit, err, busy}, 0);
    reset = 1'b1;
    hold(0, 0, 5);

    // Inbound passage
    snap();
    hold(1, 0, 20);
    check("in_busy_rise_edge", e_bz, 7);
    hold(1, 1, 20);
    hold(0, 1, 20);
    hold(0, 0, 20);
    check("in_enter_edge", e_en, 7);
    check("in_busy_fall_edge", e_bz, 7);
    check("in_enter_count", cnt_en - b_en, 1);
    check("in_exit_count", cnt_ex - b_ex, 0);

    // Outbound passage
    snap();
    hold(0, 1, 20);
    hold(1, 1, 20);
    hold(1, 0, 20);
    hold(0, 0, 20);
    check("out_exit_edge", e_ex, 7);
    check("out_busy_fall_same_edge", e_bz, e_ex);
    check("out_exit_count", cnt_ex - b_ex, 1);
    check("out_enter_count", cnt_en - b_en, 0);

    // Back-out
    snap();
    hold(1, 0, 20);
    hold(1, 1, 20);
    hold(1, 0, 20);
    hold(0, 0, 20);
    check("backout_pulses", (cnt_en - b_en) + (cnt_ex - b_ex) + (cnt_er - b_er), 0);
    check("backout_busy_end", busy, 0);

    // Glitch rejection
    snap();
    hold(1, 0, 3);
    hold(0, 0, 10);
    for (int i = 0; i < 30; i++) hold(0, (i % 2) == 0, 1);
    hold(0, 0, 10);
    check("glitch_pulses", (cnt_en - b_en) + (cnt_ex - b_ex) + (cnt_er - b_er), 0);
    check("glitch_busy_cycles", cnt_busy - b_bz, 0);

    // Illegal simultaneous block
    snap();
    hold(1, 1, 20);
    check("illegal_err_edge", e_er, 7);
    check("illegal_busy_held", busy, 1);
    hold(0, 0, 20);
    check("illegal_busy_fall_edge", e_bz, 7);
    check("illegal_err_count", cnt_er - b_er, 1);
    check("illegal_no_passage", (cnt_en - b_en) + (cnt_ex - b_ex), 0);
    hold(1, 0, 20);
    hold(1, 1, 20);
    hold(0, 1, 20);
    hold(0, 0, 20);
    check("after_err_enter_count", cnt_en - b_en, 1);

    // Reset mid-passage
    snap();
    hold(1, 0, 20);
    hold(1, 1, 20);
    check("pre_reset_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", {enter, exit, err, busy}, 0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    hold(1, 1, 20);
    check("post_reset_err_edge", e_er, 7);
    hold(0, 1, 20);
    hold(0, 0, 20);
    check("post_reset_enter_count", cnt_en - b_en, 0);
    check("post_reset_err_count", cnt_er - b_er, 1);
    check("post_reset_busy_end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
